// File: rtl/alu_control_pkg.sv
// Shared types for the ALU control sequencer: ALU function codes, instruction
// opcodes, sequencer states and status-flag bit positions.
package opcodes;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned FLAGS_W = 4;

   localparam int unsigned FLAGS_Z = 0;
   localparam int unsigned FLAGS_C = 1;
   localparam int unsigned FLAGS_V = 2;
   localparam int unsigned FLAGS_N = 3;

   typedef enum logic [3:0] {
      FnNOP = 4'd0,
      FnADD = 4'd1,
      FnADC = 4'd2,
      FnSUB = 4'd3,
      FnAND = 4'd4,
      FnOR  = 4'd5,
      FnNOT = 4'd6,
      FnLSL = 4'd7,
      FnLSR = 4'd8,
      FnMem = 4'd9
   } alu_functions_t;

   typedef enum logic [4:0] {
      OP_NOP  = 5'b00000,
      OP_ADD  = 5'b00001,
      OP_ADC  = 5'b00010,
      OP_SUB  = 5'b00011,
      OP_AND  = 5'b00100,
      OP_OR   = 5'b00101,
      OP_NOT  = 5'b00110,
      OP_LSL  = 5'b00111,
      OP_LSR  = 5'b01000,
      OP_ADDI = 5'b01001,
      OP_SUBI = 5'b01010,
      OP_LDW  = 5'b01100,
      OP_STW  = 5'b01101,
      OP_BR   = 5'b10000,
      OP_BEQ  = 5'b10001,
      OP_BNE  = 5'b10010,
      OP_BCS  = 5'b10011,
      OP_BMI  = 5'b10100,
      OP_HALT = 5'b11111
   } instr_opcode_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      MEM   = 2'd2,
      HALT  = 2'd3
   } ctrl_state_t;

   // ALU function for register/immediate arithmetic opcodes; FnNOP otherwise
   function automatic alu_functions_t alu_fn(input instr_opcode_t op);
      alu_functions_t fn;
      fn = FnNOP;
      case (op)
         OP_ADD, OP_ADDI: fn = FnADD;
         OP_ADC:          fn = FnADC;
         OP_SUB, OP_SUBI: fn = FnSUB;
         OP_AND:          fn = FnAND;
         OP_OR:           fn = FnOR;
         OP_NOT:          fn = FnNOT;
         OP_LSL:          fn = FnLSL;
         OP_LSR:          fn = FnLSR;
         default:         fn = FnNOP;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/alu_control_cond_eval.sv
// Branch condition evaluation against the latched status flags.
module cond_eval
   import opcodes::*;
(
   input  instr_opcode_t       BranchOp,
   input  logic [FLAGS_W-1:0]  Status,
   output logic                Taken
);

   // No branch tests overflow; the bit is kept on the port for completeness
   logic w_unused_v;
   assign w_unused_v = Status[FLAGS_V];

   always_comb begin
      Taken = 1'b0;
      case (BranchOp)
         OP_BR:   Taken = 1'b1;
         OP_BEQ:  Taken = Status[FLAGS_Z];
         OP_BNE:  Taken = ~Status[FLAGS_Z];
         OP_BCS:  Taken = Status[FLAGS_C];
         OP_BMI:  Taken = Status[FLAGS_N];
         default: Taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_control.sv
// Multi-cycle instruction sequencer driving the ALU and datapath.
// Optional illegal-opcode trap: define ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_control
   import opcodes::*;
#(
   parameter int unsigned IMM_W = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [INSTR_W-1:0]  Instr,
   input  logic                InstrValid,
   output logic                InstrAck,
   input  logic                MemReady,
   input  logic [FLAGS_W-1:0]  Flags,
   output alu_functions_t      AluOp,
   output logic [REG_W-1:0]    Ra,
   output logic [REG_W-1:0]    Rb,
   output logic [REG_W-1:0]    Rd,
   output logic                ImmSel,
   output logic [IMM_W-1:0]    Imm,
   output logic                RegWe,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                PcInc,
   output logic                PcLoad,
   output logic [FLAGS_W-1:0]  StatusReg,
   output logic                Halted
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                IllegalOp
`endif
);

   ctrl_state_t          r_state;
   ctrl_state_t          w_state_nx;
   logic [INSTR_W-1:0]   r_ir;
   logic [FLAGS_W-1:0]   r_status;
   instr_opcode_t        w_op;
   logic                 w_is_alu;
   logic                 w_is_imm_alu;
   logic                 w_is_mem;
   logic                 w_is_br;
   logic                 w_is_legal;
   logic                 w_taken;

   assign w_op = instr_opcode_t'(r_ir[15:11]);

   always_comb begin
      w_is_alu     = 1'b0;
      w_is_imm_alu = 1'b0;
      w_is_mem     = 1'b0;
      w_is_br      = 1'b0;
      w_is_legal   = 1'b1;
      case (w_op)
         OP_ADD, OP_ADC, OP_SUB, OP_AND,
         OP_OR, OP_NOT, OP_LSL, OP_LSR:    w_is_alu = 1'b1;
         OP_ADDI, OP_SUBI: begin
            w_is_alu     = 1'b1;
            w_is_imm_alu = 1'b1;
         end
         OP_LDW, OP_STW:                   w_is_mem = 1'b1;
         OP_BR, OP_BEQ, OP_BNE,
         OP_BCS, OP_BMI:                   w_is_br  = 1'b1;
         OP_NOP, OP_HALT:                  w_is_legal = 1'b1;
         default:                          w_is_legal = 1'b0;
      endcase
   end

   cond_eval u_cond_eval (
      .BranchOp (w_op),
      .Status   (r_status),
      .Taken    (w_taken)
   );

   assign Rd        = r_ir[10:8];
   assign Ra        = r_ir[7:5];
   assign Rb        = r_ir[4:2];
   assign Imm       = w_is_mem ? IMM_W'($signed(r_ir[4:0])) : IMM_W'($signed(r_ir[7:0]));
   assign InstrAck  = (r_state == FETCH) & InstrValid;
   assign Halted    = (r_state == HALT);
   assign StatusReg = r_status;

   // Next state and datapath controls, decoded from state and IR
   always_comb begin
      w_state_nx = r_state;
      AluOp      = FnNOP;
      ImmSel     = 1'b0;
      RegWe      = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      PcInc      = 1'b0;
      PcLoad     = 1'b0;
      case (r_state)
         FETCH: begin
            if (InstrValid) w_state_nx = EXEC;
         end
         EXEC: begin
            w_state_nx = FETCH;
            if (w_is_alu) begin
               AluOp  = alu_fn(w_op);
               ImmSel = w_is_imm_alu;
               RegWe  = 1'b1;
               PcInc  = 1'b1;
            end else if (w_is_mem) begin
               AluOp      = FnADD;
               ImmSel     = 1'b1;
               MemRead    = (w_op == OP_LDW);
               MemWrite   = (w_op == OP_STW);
               w_state_nx = MEM;
            end else if (w_is_br) begin
               PcLoad = w_taken;
               ImmSel = w_taken;
               PcInc  = ~w_taken;
            end else if (w_op == OP_HALT) begin
               w_state_nx = HALT;
            end else if (!w_is_legal) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
               w_state_nx = HALT;
`else
               PcInc = 1'b1;
`endif
            end else begin
               PcInc = 1'b1;
            end
         end
         MEM: begin
            MemRead  = (w_op == OP_LDW);
            MemWrite = (w_op == OP_STW);
            if (MemReady) begin
               w_state_nx = FETCH;
               PcInc      = 1'b1;
               if (w_op == OP_LDW) begin
                  AluOp = FnMem;
                  RegWe = 1'b1;
               end
            end
         end
         HALT: w_state_nx = HALT;
         default: w_state_nx = FETCH;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state  <= FETCH;
         r_ir     <= '0;
         r_status <= '0;
      end else begin
         r_state <= w_state_nx;
         if (InstrAck) r_ir <= Instr;
         // Flags are captured as an ALU op leaves EXEC so a following branch sees them
         if (r_state == EXEC && w_is_alu) r_status <= Flags;
      end
   end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                                 r_illegal <= 1'b0;
      else if (r_state == EXEC && !w_is_legal)   r_illegal <= 1'b1;
   end

   assign IllegalOp = r_illegal;
`endif

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for the ALU control sequencer.
module tb_alu_control;
   import opcodes::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] Instr;
   logic        InstrValid;
   logic        InstrAck;
   logic        MemReady;
   logic [3:0]  Flags;
   alu_functions_t AluOp;
   logic [2:0]  Ra, Rb, Rd;
   logic        ImmSel;
   logic [15:0] Imm;
   logic        RegWe, MemRead, MemWrite, PcInc, PcLoad;
   logic [3:0]  StatusReg;
   logic        Halted;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic        IllegalOp;
`endif

   int errors = 0;
   int checks = 0;
   int wr_cnt;
   logic we_seen;

   alu_control #(.IMM_W(16)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Instr      (Instr),
      .InstrValid (InstrValid),
      .InstrAck   (InstrAck),
      .MemReady   (MemReady),
      .Flags      (Flags),
      .AluOp      (AluOp),
      .Ra         (Ra),
      .Rb         (Rb),
      .Rd         (Rd),
      .ImmSel     (ImmSel),
      .Imm        (Imm),
      .RegWe      (RegWe),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .PcInc      (PcInc),
      .PcLoad     (PcLoad),
      .StatusReg  (StatusReg),
      .Halted     (Halted)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      ,
      .IllegalOp  (IllegalOp)
`endif
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs settle before the following one
   task automatic cyc;
      @(posedge Clock);
      #2;
   endtask

   function automatic logic [4:0] strobes;
      return {RegWe, MemRead, MemWrite, PcInc, PcLoad};
   endfunction

   initial begin
      Reset = 1'b1; Instr = 16'h0000; InstrValid = 1'b0; MemReady = 1'b0; Flags = 4'h0;
      #3;
      chk("rst_aluop",   32'(AluOp), 32'(FnNOP));
      chk("rst_strobes", 32'(strobes()), 32'h0);
      chk("rst_status",  32'(StatusReg), 32'h0);
      chk("rst_halted",  32'(Halted), 32'h0);
      cyc;
      Reset = 1'b0;

      // Idle fetch: nothing accepted, nothing strobed
      for (int i = 0; i < 5; i++) begin
         cyc;
         chk("idle_ack",     32'(InstrAck), 32'h0);
         chk("idle_strobes", 32'(strobes()), 32'h0);
      end

      // ADD 0x0A80: Rd=2 Ra=4 Rb=0
      Instr = 16'h0A80; InstrValid = 1'b1;
      #2 chk("add_ack", 32'(InstrAck), 32'h1);
      cyc;
      InstrValid = 1'b0; Flags = 4'b0010;
      #2;
      chk("add_aluop", 32'(AluOp), 32'(FnADD));
      chk("add_rd",    32'(Rd), 32'h2);
      chk("add_ra",    32'(Ra), 32'h4);
      chk("add_rb",    32'(Rb), 32'h0);
      chk("add_strb",  32'(strobes()), 32'b10010);
      cyc;
      chk("add_status", 32'(StatusReg), 32'b0010);
      chk("add_after",  32'(AluOp), 32'(FnNOP));

      // LDW 0x6121, reset while waiting in MEM
      Instr = 16'h6121; InstrValid = 1'b1;
      cyc;
      InstrValid = 1'b0; MemReady = 1'b0;
      #2 chk("ldw_exec_rd", 32'(MemRead), 32'h1);
      cyc;
      chk("ldw_mem_rd", 32'(MemRead), 32'h1);
      #1 Reset = 1'b1;
      #1;
      chk("ldw_rst_rd",     32'(MemRead), 32'h0);
      chk("ldw_rst_status", 32'(StatusReg), 32'h0);
      chk("ldw_rst_aluop",  32'(AluOp), 32'(FnNOP));
      cyc;
      Reset = 1'b0;

      // SUB sets Z, BEQ -2 taken
      Instr = 16'h1800; InstrValid = 1'b1;
      #2 chk("sub_ack", 32'(InstrAck), 32'h1);
      cyc;
      Flags = 4'b0001; Instr = 16'h88FE;
      #2;
      chk("sub_aluop", 32'(AluOp), 32'(FnSUB));
      chk("sub_noack", 32'(InstrAck), 32'h0);
      cyc;
      chk("beq_ack", 32'(InstrAck), 32'h1);
      cyc;
      InstrValid = 1'b0;
      #2;
      chk("beq_t_strb",   32'(strobes()), 32'b00001);
      chk("beq_t_immsel", 32'(ImmSel), 32'h1);
      chk("beq_t_imm",    32'(Imm), 32'hFFFE);

      // SUB clears Z, BEQ not taken
      cyc;
      Instr = 16'h1800; InstrValid = 1'b1;
      cyc;
      Flags = 4'b0000; Instr = 16'h88FE;
      cyc;
      chk("sub2_status", 32'(StatusReg), 32'h0);
      cyc;
      InstrValid = 1'b0;
      #2 chk("beq_nt_strb", 32'(strobes()), 32'b00010);

      // ADDI Rd=1 imm8=5
      cyc;
      Instr = 16'h4905; InstrValid = 1'b1;
      cyc;
      InstrValid = 1'b0;
      #2;
      chk("addi_aluop",  32'(AluOp), 32'(FnADD));
      chk("addi_immsel", 32'(ImmSel), 32'h1);
      chk("addi_imm",    32'(Imm), 32'h0005);

      // STW 0x6BE3, MemReady low for EXEC and two MEM cycles
      cyc;
      Instr = 16'h6BE3; InstrValid = 1'b1; MemReady = 1'b0;
      cyc;
      InstrValid = 1'b0;
      #2;
      chk("stw_aluop",  32'(AluOp), 32'(FnADD));
      chk("stw_immsel", 32'(ImmSel), 32'h1);
      chk("stw_imm",    32'(Imm), 32'h0003);
      chk("stw_rd",     32'(Rd), 32'h3);
      chk("stw_ra",     32'(Ra), 32'h7);
      wr_cnt = 0; we_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc;
         MemReady = (i == 3);
         #1;
         if (MemWrite) wr_cnt++;
         if (RegWe || MemRead) we_seen = 1'b1;
         chk("stw_pcinc", 32'(PcInc), (i == 3) ? 32'h1 : 32'h0);
      end
      cyc;
      MemReady = 1'b0;
      #1;
      chk("stw_done_wr", 32'(MemWrite), 32'h0);
      chk("stw_wr_cnt",  32'(wr_cnt), 32'd4);
      chk("stw_no_we",   32'(we_seen), 32'h0);

      // Illegal opcode 11000
      Instr = 16'hC000; InstrValid = 1'b1;
      cyc;
      InstrValid = 1'b0;
      #2;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      chk("ill_strb", 32'(strobes()), 32'h0);
      cyc;
      chk("ill_halted", 32'(Halted), 32'h1);
      chk("ill_flag",   32'(IllegalOp), 32'h1);
`else
      chk("ill_strb", 32'(strobes()), 32'b00010);
      cyc;
      chk("ill_halted", 32'(Halted), 32'h0);

      // HALT, then instructions offered forever
      Instr = 16'hF800; InstrValid = 1'b1;
      cyc;
      #2 chk("halt_exec_strb", 32'(strobes()), 32'h0);
      chk("halt_exec_h", 32'(Halted), 32'h0);
      cyc;
`endif
      Instr = 16'h0A80; InstrValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc;
         chk("halt_h",    32'(Halted), 32'h1);
         chk("halt_ack",  32'(InstrAck), 32'h0);
         chk("halt_strb", 32'(strobes()), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
